dbus_mmio_ctrl: RTL and testbench
=================================

Name: dbus_mmio_ctrl

Overview:
Data-side bus controller sitting directly downstream of the pipelined core's MEM stage. It consumes the core's daddr/ddata_w/d_rw and returns ddata_r. It decodes a 10-bit byte address space into data RAM, a GPIO block and a 32-bit timer with compare-match interrupt. Reads are combinational so the core's MEM/WB bank captures ddata_r in the same cycle; writes commit on the clock edge.

Parameters:
RAM_WORDS, 128, number of 32-bit RAM words; must be ≤128 so RAM fits below 0x200.
GPIO_W, 8, width of the GPIO input and output ports (1..32).
SYNC_STAGES, 2, flip-flop stages on gpio_in (≥2).
PRESCALE, 1, CLK cycles per timer tick (≥1).

Ports:
CLK  in  1  clock.
RESET_N  in  1  reset, asynchronous, active-low.
daddr  in  10  byte address from the core MEM stage; bits [1:0] ignored (word access only).
ddata_w  in  32  write data.
d_rw  in  1  write enable, 1 = write this cycle.
ddata_r  out  32  read data, combinational from daddr.
gpio_in  in  GPIO_W  asynchronous external inputs.
gpio_out  out  GPIO_W  registered GPIO outputs.
timer_irq  out  1  level interrupt, equal to MATCH & IRQ_EN.

Behaviour:
- Address map (word-aligned, daddr[1:0] don't-care):
  - 0x000–0x1FF: RAM, index daddr[8:2]. Indices ≥RAM_WORDS read 0 and ignore writes.
  - 0x200: GPIO_OUT, R/W, low GPIO_W bits.
  - 0x204: GPIO_IN, RO, synchronised value zero-extended.
  - 0x208: TCNT, R/W.
  - 0x20C: TCMP, R/W.
  - 0x210: TCTRL. bit0 EN (R/W), bit1 MATCH (RO; write 1 clears), bit2 IRQ_EN (R/W). Other bits read 0.
  - Any other 0x2xx address: reads 0, writes ignored, no error.
- Reset values: gpio_out=0, TCNT=0, TCMP=0xFFFF_FFFF, EN=0, MATCH=0, IRQ_EN=0, prescaler=0, sync chain=0, timer_irq=0. RAM contents are not reset and are undefined after power-up. ddata_r follows daddr combinationally, even during reset.
- Writes: committed on the posedge where d_rw=1. Read data in the same cycle returns the pre-write value.
- gpio_in: SYNC_STAGES-flop synchroniser. A change becomes visible at GPIO_IN after SYNC_STAGES edges.
- Timer:
  - When EN=1, the prescaler counts 0..PRESCALE-1. A tick occurs when it wraps.
  - On a tick, TCNT <= TCNT+1, modulo 2^32 (0xFFFF_FFFF wraps to 0).
  - When EN=0, the prescaler holds and TCNT holds.
  - A bus write to TCNT overrides that cycle's increment and resets the prescaler to 0.
  - Clearing EN does not clear TCNT.
- Match:
  - MATCH is set on the edge where TCNT's next value equals TCMP and that value results from a tick. Bus writes to TCNT or TCMP never set MATCH.
  - MATCH is sticky until software writes 1 to TCTRL bit1.
  - If a set and a clear occur in the same cycle, the set wins.
- timer_irq is a combinational AND of registered bits, so there are no glitches from bus inputs.
- Asserting reset mid-operation immediately forces every register to its reset value. The next write after deassertion behaves normally.

Decomposition:
- Package dbus_mmio_pkg:
  - address constants ADDR_GPIO_OUT, ADDR_GPIO_IN, ADDR_TCNT, ADDR_TCMP, ADDR_TCTRL;
  - TCTRL bit indices EN_BIT, MATCH_BIT, IRQEN_BIT;
  - TCMP reset constant.
- One sub-module, mmio_timer, holding the prescaler, TCNT, TCMP, TCTRL and match logic. Its interface is write strobes plus write data in, register values and irq out.
- The top level holds the RAM array, GPIO registers, synchroniser and address decode/read mux.

Test Plan:
1. Write 0xDEADBEEF to 0x010, then read 0x010 and 0x013 → both return 0xDEADBEEF. Read 0x014 → unaffected.
2. Write 0xA5 to 0x200 → gpio_out=0xA5 after that edge. Drive gpio_in=0x3C → reading 0x204 returns 0x3C exactly 2 cycles later, and 0 before that.
3. PRESCALE=1, TCMP=5, TCTRL=0x5 → TCNT counts 1,2,…. MATCH and timer_irq go to 1 on the edge where TCNT becomes 5. Writing 0x7 to TCTRL clears MATCH and keeps EN and IRQ_EN.
4. Write TCNT=0xFFFF_FFFE with EN=1 → TCNT goes 0xFFFF_FFFF then 0 on successive ticks, with no MATCH unless TCMP matches. A TCNT write coincident with a tick loads the written value.
5. Set MATCH pending, then in one cycle write TCTRL=0x7 while the next tick matches again → MATCH remains 1.
6. Pulse RESET_N low mid-count with gpio_out=0xFF → gpio_out=0, TCNT=0, TCMP=0xFFFF_FFFF, timer_irq=0 asynchronously. A write to an unmapped address such as 0x3F0 leaves all state unchanged and reads back 0.

Source files
------------

// File: rtl/dbus_mmio_pkg.sv
// Shared address map, TCTRL bit positions and timer reset constants for the data-bus MMIO block.
package dbus_mmio_pkg;

  localparam logic [9:0] ADDR_GPIO_OUT = 10'h200;
  localparam logic [9:0] ADDR_GPIO_IN  = 10'h204;
  localparam logic [9:0] ADDR_TCNT     = 10'h208;
  localparam logic [9:0] ADDR_TCMP     = 10'h20C;
  localparam logic [9:0] ADDR_TCTRL    = 10'h210;

  localparam int EN_BIT    = 0;
  localparam int MATCH_BIT = 1;
  localparam int IRQEN_BIT = 2;

  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timer.sv
// 32-bit up-counting timer with prescaler, compare register and sticky match flag.
module mmio_timer
  import dbus_mmio_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        tcnt_we,
  input  logic        tcmp_we,
  input  logic        tctrl_we,
  input  logic [31:0] wdata,
  output logic [31:0] tcnt,
  output logic [31:0] tcmp,
  output logic [31:0] tctrl,
  output logic        irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc;
  logic          en;
  logic          match;
  logic          irq_en;
  logic          tick;
  logic          match_set;
  logic          match_clr;
  logic [31:0]   tcnt_inc;

  assign tick      = en && (presc == PW'(PRESCALE - 1));
  assign tcnt_inc  = tcnt + 32'd1;
  // Only a tick can raise MATCH; a bus load of TCNT suppresses the tick's effect.
  assign match_set = tick && !tcnt_we && (tcnt_inc == tcmp);
  assign match_clr = tctrl_we && wdata[MATCH_BIT];

  // Prescaler: free-runs while enabled, restarts on any TCNT load.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)      presc <= '0;
    else if (tcnt_we)  presc <= '0;
    else if (en)       presc <= tick ? '0 : presc + PW'(1);
  end

  // Counter and compare registers; a bus write wins over the tick increment.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tcnt <= '0;
      tcmp <= TCMP_RST;
    end else begin
      if (tcnt_we)   tcnt <= wdata;
      else if (tick) tcnt <= tcnt_inc;
      if (tcmp_we)   tcmp <= wdata;
    end
  end

  // Control bits; a simultaneous set beats a write-1-to-clear of MATCH.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      en     <= 1'b0;
      irq_en <= 1'b0;
      match  <= 1'b0;
    end else begin
      if (tctrl_we) begin
        en     <= wdata[EN_BIT];
        irq_en <= wdata[IRQEN_BIT];
      end
      if (match_set)      match <= 1'b1;
      else if (match_clr) match <= 1'b0;
    end
  end

  assign tctrl = {29'd0, irq_en, match, en};
  assign irq   = match & irq_en;

endmodule

// File: rtl/dbus_mmio_ctrl.sv
// Data-side bus controller: RAM, GPIO and timer behind a 10-bit byte address map.
module dbus_mmio_ctrl
  import dbus_mmio_pkg::*;
#(
  parameter int RAM_WORDS   = 128,
  parameter int GPIO_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [9:0]        daddr,
  input  logic [31:0]       ddata_w,
  input  logic              d_rw,
  output logic [31:0]       ddata_r,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  logic [31:0]       ram [RAM_WORDS];
  logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
  logic [9:0]        word_addr;
  logic [6:0]        ram_idx;
  logic              ram_hit;
  logic              sel_gpio_out, sel_gpio_in, sel_tcnt, sel_tcmp, sel_tctrl;
  logic [31:0]       tcnt, tcmp, tctrl;

  assign word_addr    = {daddr[9:2], 2'b00};
  assign ram_idx      = daddr[8:2];
  assign ram_hit      = !daddr[9] && ({1'b0, ram_idx} < 8'(RAM_WORDS));
  assign sel_gpio_out = (word_addr == ADDR_GPIO_OUT);
  assign sel_gpio_in  = (word_addr == ADDR_GPIO_IN);
  assign sel_tcnt     = (word_addr == ADDR_TCNT);
  assign sel_tcmp     = (word_addr == ADDR_TCMP);
  assign sel_tctrl    = (word_addr == ADDR_TCTRL);

  // RAM write port; contents intentionally have no reset.
  always_ff @(posedge CLK) begin
    if (d_rw && ram_hit) ram[ram_idx] <= ddata_w;
  end

  // GPIO output register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                gpio_out <= '0;
    else if (d_rw && sel_gpio_out) gpio_out <= ddata_w[GPIO_W-1:0];
  end

  // Multi-flop synchroniser for the asynchronous GPIO inputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  mmio_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .tcnt_we  (d_rw && sel_tcnt),
    .tcmp_we  (d_rw && sel_tcmp),
    .tctrl_we (d_rw && sel_tctrl),
    .wdata    (ddata_w),
    .tcnt     (tcnt),
    .tcmp     (tcmp),
    .tctrl    (tctrl),
    .irq      (timer_irq)
  );

  // Combinational read mux so the core captures data in the same cycle.
  always_comb begin
    ddata_r = '0;
    if (ram_hit)           ddata_r = ram[ram_idx];
    else if (sel_gpio_out) ddata_r = 32'(gpio_out);
    else if (sel_gpio_in)  ddata_r = 32'(sync_q[SYNC_STAGES-1]);
    else if (sel_tcnt)     ddata_r = tcnt;
    else if (sel_tcmp)     ddata_r = tcmp;
    else if (sel_tctrl)    ddata_r = tctrl;
  end

endmodule

// File: tb/tb_dbus_mmio_ctrl.sv
// Self-checking bench for dbus_mmio_ctrl: vector table plus timer/GPIO/reset sequences.
module tb_dbus_mmio_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [9:0]  daddr = '0;
  logic [31:0] ddata_w = '0;
  logic        d_rw = 1'b0;
  logic [31:0] ddata_r;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        rw;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  dbus_mmio_ctrl #(
    .RAM_WORDS(128), .GPIO_W(8), .SYNC_STAGES(2), .PRESCALE(1)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .ddata_w(ddata_w), .d_rw(d_rw),
    .ddata_r(ddata_r), .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input string name, input logic [31:0] act);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, actual %h", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", name, act, e);
      end
    end
  endtask

  // Drive one bus cycle at the falling edge; ddata_r is captured 1 ns later, commit at next rise.
  task automatic drive(input logic rw, input logic [9:0] a, input logic [31:0] w);
    @(negedge CLK);
    d_rw = rw; daddr = a; ddata_w = w;
    #1 rd = ddata_r;
  endtask

  task automatic drive_chk(input string name, input logic rw, input logic [9:0] a,
                           input logic [31:0] w, input logic [31:0] e);
    push_exp(e);
    drive(rw, a, w);
    pop_cmp(name, rd);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] e);
    push_exp(e);
    pop_cmp(name, act);
  endtask

  initial begin
    // Reset state and basic map, with the timer disabled.
    vecs.push_back('{1'b0, 10'h200, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b0, 10'h208, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b0, 10'h20C, 32'h0,         1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{1'b0, 10'h210, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b1, 10'h014, 32'h1111_1111, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 10'h010, 32'hDEAD_BEEF, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 10'h010, 32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 10'h013, 32'h0,         1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b0, 10'h014, 32'h0,         1'b1, 32'h1111_1111});
    vecs.push_back('{1'b1, 10'h200, 32'hFFFF_FFA5, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 10'h200, 32'h0,         1'b1, 32'hA5});
    vecs.push_back('{1'b1, 10'h200, 32'h5A,        1'b1, 32'hA5});
    vecs.push_back('{1'b1, 10'h200, 32'hA5,        1'b1, 32'h5A});
    vecs.push_back('{1'b1, 10'h3F0, 32'h1234_5678, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 10'h3F0, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b1, 10'h21C, 32'hCAFE_F00D, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 10'h21C, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b1, 10'h204, 32'hFF,        1'b0, 32'h0});
    vecs.push_back('{1'b0, 10'h204, 32'h0,         1'b1, 32'h0});
    vecs.push_back('{1'b0, 10'h200, 32'h0,         1'b1, 32'hA5});
    vecs.push_back('{1'b1, 10'h20C, 32'h77,        1'b0, 32'h0});
    vecs.push_back('{1'b0, 10'h20F, 32'h0,         1'b1, 32'h77});
    vecs.push_back('{1'b0, 10'h208, 32'h0,         1'b1, 32'h0});

    chk("irq_in_reset", {31'd0, timer_irq}, 32'h0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].chk) push_exp(vecs[i].exp);
      drive(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      if (vecs[i].chk) pop_cmp($sformatf("vec%0d", i), rd);
    end
    chk("gpio_out_port", {24'd0, gpio_out}, 32'hA5);

    // GPIO input synchroniser latency.
    @(negedge CLK);
    gpio_in = 8'h3C; d_rw = 1'b0; daddr = 10'h204;
    #1 chk("gpio_in_lat0", ddata_r, 32'h0);
    drive_chk("gpio_in_lat1", 1'b0, 10'h204, 32'h0, 32'h0);
    drive_chk("gpio_in_lat2", 1'b0, 10'h204, 32'h0, 32'h3C);

    // Timer counts up to TCMP=5 and raises MATCH/irq on that edge.
    drive(1'b1, 10'h20C, 32'd5);
    drive(1'b1, 10'h210, 32'h5);
    drive_chk("tcnt_start", 1'b0, 10'h208, 32'h0, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      drive_chk($sformatf("tcnt_%0d", i), 1'b0, 10'h208, 32'h0, 32'(i));
      chk($sformatf("irq_%0d", i), {31'd0, timer_irq}, (i == 5) ? 32'h1 : 32'h0);
    end
    drive_chk("tctrl_match", 1'b0, 10'h210, 32'h0, 32'h7);
    drive_chk("tctrl_clr_wr", 1'b1, 10'h210, 32'h7, 32'h7);
    drive_chk("tctrl_cleared", 1'b0, 10'h210, 32'h0, 32'h5);
    chk("irq_cleared", {31'd0, timer_irq}, 32'h0);

    // Wrap through 0xFFFF_FFFF; TCNT writes override the coincident tick.
    drive(1'b1, 10'h208, 32'hFFFF_FFFE);
    drive_chk("wrap_fe", 1'b0, 10'h208, 32'h0, 32'hFFFF_FFFE);
    drive_chk("wrap_ff", 1'b0, 10'h208, 32'h0, 32'hFFFF_FFFF);
    drive_chk("wrap_00", 1'b0, 10'h208, 32'h0, 32'h0);
    drive_chk("wrap_01", 1'b0, 10'h208, 32'h0, 32'h1);
    drive_chk("wrap_nomatch", 1'b0, 10'h210, 32'h0, 32'h5);
    drive(1'b1, 10'h208, 32'd100);
    drive_chk("tcnt_load_tick", 1'b0, 10'h208, 32'h0, 32'd100);

    // Bus write of TCNT equal to TCMP must not set MATCH.
    drive(1'b1, 10'h20C, 32'd200);
    drive(1'b1, 10'h208, 32'd200);
    drive_chk("busw_nomatch", 1'b0, 10'h210, 32'h0, 32'h5);

    // Pending MATCH, then clear coincident with a new match: set wins.
    drive(1'b1, 10'h20C, 32'd12);
    drive(1'b1, 10'h208, 32'd10);
    drive_chk("m_10", 1'b0, 10'h208, 32'h0, 32'd10);
    drive_chk("m_11", 1'b0, 10'h208, 32'h0, 32'd11);
    drive_chk("m_pending", 1'b0, 10'h210, 32'h0, 32'h7);
    drive(1'b1, 10'h20C, 32'd15);
    drive(1'b1, 10'h210, 32'h7);
    drive_chk("set_wins", 1'b0, 10'h210, 32'h0, 32'h7);
    chk("set_wins_irq", {31'd0, timer_irq}, 32'h1);
    drive(1'b1, 10'h210, 32'h7);
    drive_chk("clr_after", 1'b0, 10'h210, 32'h0, 32'h5);

    // Mid-count asynchronous reset with gpio_out=0xFF and irq asserted.
    drive(1'b1, 10'h200, 32'hFF);
    drive(1'b1, 10'h20C, 32'd50);
    drive(1'b1, 10'h208, 32'd48);
    drive(1'b0, 10'h208, 32'h0);
    drive(1'b0, 10'h208, 32'h0);
    drive_chk("pre_rst_tctrl", 1'b0, 10'h210, 32'h0, 32'h7);
    chk("pre_rst_irq", {31'd0, timer_irq}, 32'h1);
    chk("pre_rst_gpio", {24'd0, gpio_out}, 32'hFF);
    @(negedge CLK);
    d_rw = 1'b0; daddr = 10'h208;
    #2 RESET_N = 1'b0;
    #1 chk("rst_tcnt", ddata_r, 32'h0);
    chk("rst_gpio", {24'd0, gpio_out}, 32'h0);
    chk("rst_irq", {31'd0, timer_irq}, 32'h0);
    daddr = 10'h20C;
    #1 chk("rst_tcmp", ddata_r, 32'hFFFF_FFFF);
    @(negedge CLK);
    RESET_N = 1'b1;
    drive(1'b1, 10'h200, 32'h33);
    drive_chk("post_rst_wr", 1'b0, 10'h200, 32'h0, 32'h33);
    drive_chk("post_rst_tctrl", 1'b0, 10'h210, 32'h0, 32'h0);
    drive_chk("post_rst_tcnt", 1'b0, 10'h208, 32'h0, 32'h0);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
